// File: rtl/cps3_timing_monitor.sv
// CPS3 timing monitor: measures DE geometry per line/frame and runs the SEARCH/VERIFY/LOCKED lock FSM.
// Define CPS3_TMON_CRC_EN to add the per-frame CRC-16-CCITT of the active pixels on frame_crc_o.
module cps3_timing_monitor #(
    parameter int unsigned LOCK_FRAMES    = 3,
    parameter int unsigned UNLOCK_FRAMES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 262143
) (
    input  logic        PCLK_i,
    input  logic        RESET_i,
    input  logic        DE_i,
    input  logic        frame_change_i,
    input  logic [9:0]  h_active_i,
    input  logic [9:0]  v_active_i,
    input  logic [9:0]  h_total_i,
    input  logic [9:0]  v_total_i,
    input  logic [4:0]  R_i,
    input  logic [4:0]  G_i,
    input  logic [4:0]  B_i,
    output logic        locked_o,
    output logic [1:0]  state_o,
    output logic        mode_change_o,
    output logic [9:0]  meas_h_active_o,
    output logic [9:0]  meas_v_active_o,
    output logic [7:0]  err_cnt_o,
    output logic [15:0] frame_crc_o
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam logic [9:0]  CNT_MAX  = 10'h3FF;
    localparam logic [17:0] TMO_MAX  = 18'(TIMEOUT_CYCLES);
    localparam logic [4:0]  LOCK_N   = 5'(LOCK_FRAMES);
    localparam logic [4:0]  UNLOCK_N = 5'(UNLOCK_FRAMES);

    logic        de_q;
    logic        fc_q;
    logic [9:0]  pix_q, pix_d;
    logic [9:0]  line_q, line_d;
    logic [9:0]  ref_w_q, ref_w_d;
    logic        frame_bad_q, frame_bad_d;
    logic [9:0]  prev_ht_q, prev_ht_d;
    logic [9:0]  prev_vt_q, prev_vt_d;
    logic [9:0]  meas_h_q, meas_h_d;
    logic [9:0]  meas_v_q, meas_v_d;
    logic        mode_change_q, mode_change_d;
    logic        first_frame_q, first_frame_d;
    logic [17:0] tmo_q, tmo_d;

    state_e      state_q, state_d;
    logic [3:0]  good_q, good_d;
    logic [3:0]  miss_q, miss_d;
    logic [7:0]  err_q, err_d;
    logic        locked_q, locked_d;

    logic        de_fall;
    logic        boundary;
    logic        timeout;
    logic        frame_ok;
    logic        geom_diff;
    logic [9:0]  line_eff;
    logic [9:0]  ref_w_eff;
    logic        bad_eff;
    logic [4:0]  good_inc;
    logic [4:0]  miss_inc;

    // NOTE: every combinational output is given a default first, so no path can infer a latch.
    always_comb begin
        de_fall   = de_q & ~DE_i;
        boundary  = frame_change_i & ~fc_q;
        timeout   = (tmo_q == TMO_MAX);
        line_eff  = line_q;
        ref_w_eff = ref_w_q;
        bad_eff   = frame_bad_q;
        // A line ending in the boundary cycle still belongs to the frame being closed.
        if (de_fall) begin
            if (line_q != CNT_MAX) begin
                line_eff = line_q + 10'd1;
            end
            if (line_q == 10'd0) begin
                ref_w_eff = pix_q;
            end else if (pix_q != ref_w_q) begin
                bad_eff = 1'b1;
            end
        end
        frame_ok  = ~bad_eff & (ref_w_eff == h_active_i) & (line_eff == v_active_i)
                  & (h_total_i == prev_ht_q) & (v_total_i == prev_vt_q);
        geom_diff = (ref_w_eff != meas_h_q) | (line_eff != meas_v_q)
                  | (h_total_i != prev_ht_q) | (v_total_i != prev_vt_q);
    end

    always_comb begin
        pix_d = pix_q;
        if (de_fall) begin
            pix_d = '0;
        end else if (DE_i && (pix_q != CNT_MAX)) begin
            pix_d = pix_q + 10'd1;
        end
        line_d        = boundary ? '0 : line_eff;
        ref_w_d       = ref_w_eff;
        frame_bad_d   = boundary ? 1'b0 : bad_eff;
        prev_ht_d     = prev_ht_q;
        prev_vt_d     = prev_vt_q;
        meas_h_d      = meas_h_q;
        meas_v_d      = meas_v_q;
        mode_change_d = 1'b0;
        first_frame_d = first_frame_q;
        tmo_d         = tmo_q + 18'd1;
        if (boundary) begin
            prev_ht_d     = h_total_i;
            prev_vt_d     = v_total_i;
            meas_h_d      = ref_w_eff;
            meas_v_d      = line_eff;
            mode_change_d = ~first_frame_q & geom_diff;
            first_frame_d = 1'b0;
            tmo_d         = '0;
        end
        // Losing frame boundaries makes the next frame a fresh start.
        if (timeout) begin
            tmo_d         = '0;
            first_frame_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge PCLK_i or posedge RESET_i) begin
        if (RESET_i) begin
            de_q          <= 1'b0;
            fc_q          <= 1'b0;
            pix_q         <= '0;
            line_q        <= '0;
            ref_w_q       <= '0;
            frame_bad_q   <= 1'b0;
            prev_ht_q     <= '0;
            prev_vt_q     <= '0;
            meas_h_q      <= '0;
            meas_v_q      <= '0;
            mode_change_q <= 1'b0;
            first_frame_q <= 1'b1;
            tmo_q         <= '0;
        end else begin
            de_q          <= DE_i;
            fc_q          <= frame_change_i;
            pix_q         <= pix_d;
            line_q        <= line_d;
            ref_w_q       <= ref_w_d;
            frame_bad_q   <= frame_bad_d;
            prev_ht_q     <= prev_ht_d;
            prev_vt_q     <= prev_vt_d;
            meas_h_q      <= meas_h_d;
            meas_v_q      <= meas_v_d;
            mode_change_q <= mode_change_d;
            first_frame_q <= first_frame_d;
            tmo_q         <= tmo_d;
        end
    end

    always_ff @(posedge PCLK_i or posedge RESET_i) begin
        if (RESET_i) begin
            state_q  <= ST_SEARCH;
            good_q   <= '0;
            miss_q   <= '0;
            err_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            miss_q   <= miss_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        miss_d   = miss_q;
        err_d    = err_q;
        good_inc = {1'b0, good_q} + 5'd1;
        miss_inc = {1'b0, miss_q} + 5'd1;
        if (timeout) begin
            state_d = ST_SEARCH;
            good_d  = '0;
            miss_d  = '0;
            if ((state_q == ST_LOCKED) && (err_q != 8'hFF)) begin
                err_d = err_q + 8'd1;
            end
        end else if (boundary) begin
            case (state_q)
                ST_SEARCH: begin
                    if (frame_ok) begin
                        good_d  = 4'd1;
                        state_d = (LOCK_N <= 5'd1) ? ST_LOCKED : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (!frame_ok) begin
                        state_d = ST_SEARCH;
                        good_d  = '0;
                    end else if (good_inc >= LOCK_N) begin
                        state_d = ST_LOCKED;
                        good_d  = '0;
                    end else begin
                        good_d  = good_inc[3:0];
                    end
                end
                ST_LOCKED: begin
                    if (frame_ok) begin
                        miss_d = '0;
                    end else begin
                        if (err_q != 8'hFF) begin
                            err_d = err_q + 8'd1;
                        end
                        if (miss_inc >= UNLOCK_N) begin
                            state_d = ST_SEARCH;
                            miss_d  = '0;
                        end else begin
                            miss_d  = miss_inc[3:0];
                        end
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                    good_d  = '0;
                    miss_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        locked_d = (state_d == ST_LOCKED);
    end

    assign locked_o        = locked_q;
    assign state_o         = state_q;
    assign mode_change_o   = mode_change_q;
    assign meas_h_active_o = meas_h_q;
    assign meas_v_active_o = meas_v_q;
    assign err_cnt_o       = err_q;

`ifdef CPS3_TMON_CRC_EN
    logic [15:0] crc_q, crc_d;
    logic [15:0] frame_crc_q, frame_crc_d;

    function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    // A pixel in the boundary cycle is folded into the frame being closed.
    always_comb begin
        crc_d       = DE_i ? crc16_word(crc_q, {R_i, G_i, B_i, 1'b0}) : crc_q;
        frame_crc_d = frame_crc_q;
        if (boundary) begin
            frame_crc_d = crc_d;
            crc_d       = 16'hFFFF;
        end
    end

    always_ff @(posedge PCLK_i or posedge RESET_i) begin
        if (RESET_i) begin
            crc_q       <= 16'hFFFF;
            frame_crc_q <= '0;
        end else begin
            crc_q       <= crc_d;
            frame_crc_q <= frame_crc_d;
        end
    end

    assign frame_crc_o = frame_crc_q;
`else
    logic unused_rgb;
    assign unused_rgb  = ^{R_i, G_i, B_i};
    assign frame_crc_o = 16'h0000;
`endif

endmodule

// File: tb/tb_cps3_timing_monitor.sv
// Directed bench for cps3_timing_monitor on a reduced geometry (16/20 x 12 totals, 8/11 x 6 active).
// Covers lock-in, short line, mode change, timeout, mid-frame reset and frame_crc_o.
module tb_cps3_timing_monitor;

    localparam int unsigned T_OUT = 500;
    localparam int VT = 12;
    localparam int NL = 6;

    logic        PCLK_i = 1'b0;
    logic        RESET_i;
    logic        DE_i;
    logic        frame_change_i;
    logic [9:0]  h_active_i;
    logic [9:0]  v_active_i;
    logic [9:0]  h_total_i;
    logic [9:0]  v_total_i;
    logic [4:0]  R_i;
    logic [4:0]  G_i;
    logic [4:0]  B_i;
    logic        locked_o;
    logic [1:0]  state_o;
    logic        mode_change_o;
    logic [9:0]  meas_h_active_o;
    logic [9:0]  meas_v_active_o;
    logic [7:0]  err_cnt_o;
    logic [15:0] frame_crc_o;

    int          total = 0;
    int          bad = 0;
    logic        flip = 1'b0;
    logic [15:0] model_crc = 16'hFFFF;
    logic [15:0] exp_crc = 16'h0000;

    cps3_timing_monitor #(
        .LOCK_FRAMES   (3),
        .UNLOCK_FRAMES (2),
        .TIMEOUT_CYCLES(T_OUT)
    ) dut (
        .PCLK_i         (PCLK_i),
        .RESET_i        (RESET_i),
        .DE_i           (DE_i),
        .frame_change_i (frame_change_i),
        .h_active_i     (h_active_i),
        .v_active_i     (v_active_i),
        .h_total_i      (h_total_i),
        .v_total_i      (v_total_i),
        .R_i            (R_i),
        .G_i            (G_i),
        .B_i            (B_i),
        .locked_o       (locked_o),
        .state_o        (state_o),
        .mode_change_o  (mode_change_o),
        .meas_h_active_o(meas_h_active_o),
        .meas_v_active_o(meas_v_active_o),
        .err_cnt_o      (err_cnt_o),
        .frame_crc_o    (frame_crc_o)
    );

    always #5 PCLK_i = ~PCLK_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 15; i >= 0; i--) begin
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    // One clock: drive inputs, advance past the edge, settle outputs.
    task automatic cyc(input logic de, input logic fc);
        DE_i = de;
        frame_change_i = fc;
        if (de) model_crc = crc_step(model_crc, {R_i, G_i, B_i, 1'b0});
        @(posedge PCLK_i);
        #1;
    endtask

    // Rising frame_change_i; outputs observed afterwards are the N+1 results.
    task automatic boundary();
`ifdef CPS3_TMON_CRC_EN
        exp_crc = model_crc;
`else
        exp_crc = 16'h0000;
`endif
        model_crc = 16'hFFFF;
        cyc(1'b0, 1'b1);
        check("frame_crc", frame_crc_o, exp_crc);
    endtask

    // Rest of a frame after its boundary cycle; active lines 2..7 start at pixel 2.
    task automatic body(input int ht, input int w, input int short_line);
        for (int ln = 0; ln < VT; ln++) begin
            for (int h = 0; h < ht; h++) begin
                int wl;
                wl = (ln == short_line) ? w - 1 : w;
                if (ln != 0 || h != 0) begin
                    {R_i, G_i, B_i} = (flip && ln == 4 && h == 5) ? 15'h0000 : 15'h7FFF;
                    cyc((ln >= 2) && (ln < 2 + NL) && (h >= 2) && (h < 2 + wl), (ln == 0));
                end
            end
        end
    endtask

    initial begin
        RESET_i = 1'b1;
        DE_i = 1'b0;
        frame_change_i = 1'b0;
        h_active_i = 10'd8;
        v_active_i = 10'd6;
        h_total_i = 10'd16;
        v_total_i = 10'd12;
        {R_i, G_i, B_i} = 15'h7FFF;
        repeat (3) @(posedge PCLK_i);
        #1;
        check("rst_state", state_o, 0);
        check("rst_locked", locked_o, 0);
        check("rst_mc", mode_change_o, 0);
        check("rst_mh", meas_h_active_o, 0);
        check("rst_mv", meas_v_active_o, 0);
        check("rst_err", err_cnt_o, 0);
        check("rst_crc", frame_crc_o, 0);
        RESET_i = 1'b0;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);

        // Lock-in: first boundary closes an empty frame, then three good frames.
        boundary();
        check("b1_state", state_o, 0);
        check("b1_mc_first", mode_change_o, 0);
        body(16, 8, -1);
        boundary();
        check("b2_state", state_o, 1);
        check("b2_mc", mode_change_o, 1);
        check("b2_mh", meas_h_active_o, 8);
        check("b2_mv", meas_v_active_o, 6);
        check("b2_locked", locked_o, 0);
        body(16, 8, -1);
        boundary();
        check("b3_state", state_o, 1);
        check("b3_mc", mode_change_o, 0);
        check("b3_locked", locked_o, 0);
        flip = 1'b1;
        body(16, 8, -1);
        flip = 1'b0;
        boundary();
        check("b4_state", state_o, 2);
        check("b4_locked", locked_o, 1);
        check("b4_err", err_cnt_o, 0);

        // Short line while locked: one miss, then recovery clears the miss counter.
        body(16, 8, 4);
        boundary();
        check("short_state", state_o, 2);
        check("short_err", err_cnt_o, 1);
        check("short_mc", mode_change_o, 0);
        body(16, 8, -1);
        boundary();
        check("good_state", state_o, 2);
        body(16, 8, 4);
        boundary();
        check("short2_state", state_o, 2);
        check("short2_err", err_cnt_o, 2);
        body(16, 8, -1);
        boundary();
        check("good2_state", state_o, 2);

        // Wide mode: geometry change pulses once, two misses drop lock.
        h_total_i = 10'd20;
        body(20, 11, -1);
        boundary();
        check("wide1_state", state_o, 2);
        check("wide1_err", err_cnt_o, 3);
        check("wide1_mc", mode_change_o, 1);
        check("wide1_mh", meas_h_active_o, 11);
        cyc(1'b0, 1'b1);
        check("wide1_mc_width", mode_change_o, 0);
        body(20, 11, -1);
        boundary();
        check("wide2_state", state_o, 0);
        check("wide2_locked", locked_o, 0);
        check("wide2_err", err_cnt_o, 4);
        check("wide2_mc", mode_change_o, 0);
        h_active_i = 10'd11;
        body(20, 11, -1);
        boundary();
        check("relock1", state_o, 1);
        body(20, 11, -1);
        boundary();
        check("relock2", state_o, 1);
        body(20, 11, -1);
        boundary();
        check("relock3", state_o, 2);
        check("relock3_locked", locked_o, 1);

        // Timeout: counter equals T_OUT in the last locked cycle, SEARCH the cycle after.
        repeat (T_OUT) cyc(1'b0, 1'b0);
        check("pre_tmo_state", state_o, 2);
        cyc(1'b0, 1'b0);
        check("tmo_state", state_o, 0);
        check("tmo_locked", locked_o, 0);
        check("tmo_err", err_cnt_o, 5);
        boundary();
        check("post_tmo_mc", mode_change_o, 0);
        check("post_tmo_mv", meas_v_active_o, 0);
        check("post_tmo_state", state_o, 0);
        body(20, 11, -1);
        boundary();
        check("post_tmo2_state", state_o, 1);
        check("post_tmo2_mc", mode_change_o, 1);
        body(20, 11, -1);
        boundary();
        body(20, 11, -1);
        boundary();
        check("tmo_relock", state_o, 2);

        // Mid-frame asynchronous reset while locked.
        cyc(1'b0, 1'b0);
        repeat (4) cyc(1'b1, 1'b0);
        RESET_i = 1'b1;
        #1;
        check("arst_state", state_o, 0);
        check("arst_locked", locked_o, 0);
        check("arst_err", err_cnt_o, 0);
        check("arst_mh", meas_h_active_o, 0);
        check("arst_mv", meas_v_active_o, 0);
        DE_i = 1'b0;
        frame_change_i = 1'b0;
        model_crc = 16'hFFFF;
        @(posedge PCLK_i);
        #1;
        RESET_i = 1'b0;
        cyc(1'b0, 1'b0);
        boundary();
        check("arst_b1", state_o, 0);
        body(20, 11, -1);
        boundary();
        check("arst_b2", state_o, 1);
        body(20, 11, -1);
        boundary();
        check("arst_b3", state_o, 1);
        body(20, 11, -1);
        boundary();
        check("arst_b4", state_o, 2);
        check("arst_b4_locked", locked_o, 1);
        check("arst_b4_err", err_cnt_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cps3_timing_monitor.md
Name: cps3_timing_monitor

Overview:
Downstream of the CPS3 sync/DE regenerator; consumes its registered DE/frame_change/geometry outputs.
- Measures the active window per line and per frame and checks it against the advertised h_active/v_active/h_total/v_total.
- Runs a lock state machine; drives locked/mode-change status to the scaler and OSD control.
- Passive: never modifies the video stream.

Parameters:
- LOCK_FRAMES, 3: consecutive good frames required to enter LOCKED (1..15).
- UNLOCK_FRAMES, 2: consecutive bad frames in LOCKED before dropping to SEARCH (1..15).
- TIMEOUT_CYCLES, 262143: PCLK cycles without a frame boundary before forced SEARCH (18-bit counter).

Ports:
- PCLK_i  in  1  pixel clock
- RESET_i  in  1  asynchronous active-high reset
- DE_i  in  1  data enable from upstream stage
- frame_change_i  in  1  frame marker; high for one line at frame start
- h_active_i  in  10  advertised active width
- v_active_i  in  10  advertised active height
- h_total_i  in  10  measured line length
- v_total_i  in  10  measured frame length
- R_i, G_i, B_i  in  5 each  pixel data (used only by the optional feature)
- locked_o  out  1  timing locked
- state_o  out  2  FSM state (0 SEARCH, 1 VERIFY, 2 LOCKED)
- mode_change_o  out  1  one-cycle pulse on geometry change
- meas_h_active_o  out  10  DE width of the last frame's first active line
- meas_v_active_o  out  10  DE line count of the last frame
- err_cnt_o  out  8  saturating bad-frame counter (LOCKED only)
- frame_crc_o  out  16  per-frame pixel CRC (optional feature)

Behaviour:
Reset:
- All outputs, counters and flags are 0; state is SEARCH; first_frame flag is set.

Line measurement:
- pix_ctr counts cycles with DE_i=1 and saturates at 1023.
- On a DE falling edge (DE_i=0, DE_d=1):
  - line_ctr increments (saturating at 1023).
  - If it is the first active line of the frame, ref_w <= pix_ctr.
  - Otherwise, pix_ctr != ref_w sets frame_bad.
  - pix_ctr clears.

Frame boundary:
- Defined as the frame_change_i rising edge (frame_change_i=1, fc_d=0) in cycle N.
- In cycle N+1:
  - meas_h_active_o <= ref_w; meas_v_active_o <= line_ctr.
  - frame_ok = !frame_bad & ref_w==h_active_i & line_ctr==v_active_i & h_total_i==prev_ht & v_total_i==prev_vt.
  - prev_ht/prev_vt update; line_ctr, frame_bad and the timeout counter clear.
- mode_change_o pulses in N+1 when ref_w, line_ctr, h_total_i or v_total_i differ from the previous frame. It is suppressed on the first frame after reset or timeout; first_frame clears at that boundary.
- A DE falling edge coinciding with the boundary cycle belongs to the old frame: count it before evaluation.

FSM (evaluated at N+1):
- SEARCH: frame_ok -> VERIFY with good_ctr=1. If LOCK_FRAMES==1, go straight to LOCKED.
- VERIFY: frame_ok -> good_ctr++; reaching LOCK_FRAMES -> LOCKED. Bad -> SEARCH, good_ctr=0.
- LOCKED:
  - Good frame: miss_ctr=0.
  - Bad frame: err_cnt_o++ (saturate at 255) and miss_ctr++.
  - miss_ctr reaching UNLOCK_FRAMES -> SEARCH, miss_ctr=0.
- locked_o is registered: 1 exactly while state==LOCKED.

Timeout:
- The counter increments every cycle and clears at each boundary.
- On reaching TIMEOUT_CYCLES (from any state): next cycle is SEARCH, locked_o=0, counters clear, first_frame is set.
- err_cnt_o increments if the state was LOCKED.
- The counter restarts from 0.

Other rules:
- All comparisons are 10-bit unsigned.
- Asynchronous RESET_i mid-frame restores reset values immediately; the first post-reset boundary is evaluated normally.

Optional Feature:
Macro: CPS3_TMON_CRC_EN
- Defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF) accumulates {R_i,G_i,B_i} (15 bits, MSB first, 1 bit zero-padded to 16) every cycle DE_i=1.
  - At the boundary, frame_crc_o <= crc and crc resets to 0xFFFF, same N+1 latency.
- Undefined:
  - No CRC logic; frame_crc_o is constant 0.
  - R_i/G_i/B_i are unused.

Test Plan:
1. Std timing 546x264, DE 384 px x 224 lines, LOCK_FRAMES=3 -> state_o 0->1->1->2; locked_o=1 one cycle after the 3rd boundary; meas 384/224; err_cnt_o=0.
2. Locked, switch to wide 682x264 with DE 495 -> mode_change_o single pulse; one bad frame then the next frame also bad until h_active_i updates; after 2 bad frames SEARCH, err_cnt_o=2; relock after 3 good frames.
3. Locked, one line with 383 DE pixels -> that frame bad, err_cnt_o=1, miss_ctr=1, stays LOCKED; next good frame clears miss_ctr.
4. Stop frame_change_i for 262143 cycles -> state_o=0, locked_o=0, err_cnt_o+1; first boundary after that gives no mode_change_o pulse.
5. Assert RESET_i mid-frame while LOCKED -> all outputs 0 immediately; lock regained after 3 good frames.
6. With CPS3_TMON_CRC_EN, constant pixel 0x7FFF, two identical frames -> identical nonzero frame_crc_o; flip one pixel -> differing CRC. Without the macro -> frame_crc_o=0.
